// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts one data word per handshake and serialises it as
// start bit, data bits, optional parity and stop bits, one bit per baud_tick.
module uart_tx_framer #(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int PAR_W     = (PARITY != 0) ? 1 : 0;
    localparam int FRAME_LEN = 1 + DATA_W + PAR_W + STOP_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("uart_tx_framer: DATA_W must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_framer: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_framer: STOP_BITS must be 1 or 2");
        end
        if (LSB_FIRST < 0 || LSB_FIRST > 1) begin : g_bad_order
            $error("uart_tx_framer: LSB_FIRST must be 0 or 1");
        end
    endgenerate

    logic [0:0]           state;
    logic [FRAME_LEN-1:0] sh;
    logic [CNT_W-1:0]     cnt;

    // Put the word in line order so the first data bit sits next to the start bit.
    function automatic logic [DATA_W-1:0] order_data(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (LSB_FIRST == 0) begin
            for (int i = 0; i < DATA_W; i++) begin
                r[i] = d[DATA_W-1-i];
            end
        end
        return r;
    endfunction

    function automatic logic parity_bit(input logic [DATA_W-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [DATA_W-1:0] d);
        logic [FRAME_LEN-1:0] f;
        f             = '1;
        f[0]          = 1'b0;
        f[DATA_W:1]   = order_data(d);
        if (PARITY != 0) begin
            f[DATA_W+1] = parity_bit(d);
        end
        return f;
    endfunction

    // A tick in the accept cycle is ignored because the FSM is still in IDLE then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sh         <= '1;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        sh    <= build_frame(s_data);
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (baud_tick) begin
                        sh  <= {1'b1, sh[FRAME_LEN-1:1]};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_ready = (state == IDLE);
    assign busy    = (state == SHIFT);
    assign txd     = sh[0];

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-003 The block SHALL have parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-004 The block SHALL have parameter LSB_FIRST, default 1: 1 sends data LSB first, 0 sends MSB first.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 baud_tick  input  1  one-clk-wide bit-period strobe.
REQ-008 s_valid  input  1  a data word is offered.
REQ-009 s_data  input  DATA_W  the offered data word.
REQ-010 s_ready  output  1  the framer can accept a word.
REQ-011 txd  output  1  serial line; idles high.
REQ-012 busy  output  1  a frame is in progress.
REQ-013 frame_done  output  1  one-clk pulse when a frame completes.

Function
REQ-014 FRAME_LEN SHALL equal 1 + DATA_W + (PARITY!=0) + STOP_BITS (range 7..13).
REQ-015 Illegal parameter values SHALL cause an elaboration-time error.
REQ-016 The FSM SHALL have two states, IDLE and SHIFT, plus a FRAME_LEN-wide shift register and a bit counter.
REQ-017 In IDLE, s_ready SHALL be 1, busy 0 and txd 1.
REQ-018 In SHIFT, s_ready SHALL be 0 and busy 1.
REQ-019 On a clk edge with s_valid=1 and s_ready=1 (accept), the shift register SHALL load {STOP_BITS ones, parity, ordered data, 0}, the counter SHALL clear and the state SHALL become SHIFT.
REQ-020 s_data SHALL be sampled only at accept; later changes SHALL have no effect on the frame.
REQ-021 Even parity SHALL be the XOR of all DATA_W bits; odd parity SHALL be its inverse.
REQ-022 txd SHALL equal shift register bit 0, so the start bit appears the cycle after accept.
REQ-023 A baud_tick in the accept cycle SHALL be ignored.
REQ-024 In SHIFT, each baud_tick SHALL shift the register right with 1 fill and increment the counter.
REQ-025 Bit k of the frame SHALL be held on txd from the k-th to the (k+1)-th counted baud_tick, with the start bit counted as k=0.
REQ-026 On the FRAME_LEN-th counted tick, the state SHALL return to IDLE and frame_done SHALL be 1 for exactly the following clk cycle.
REQ-027 s_ready SHALL be 1 in the same cycle that frame_done is 1.
REQ-028 Back-to-back words SHALL be accepted with at most one clk of gap and no extra idle bit period.
REQ-029 Without baud_tick, the framer SHALL hold state and txd indefinitely.
REQ-030 The counter SHALL be ceil(log2(FRAME_LEN+1)) bits wide and SHALL never wrap within a frame.

Reset
REQ-031 While rst_n=0, outputs SHALL immediately (asynchronously) be txd=1, busy=0, s_ready=1 and frame_done=0; the state SHALL be IDLE and the shift register all ones.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse.
REQ-033 The first accept SHALL be possible on the first clk edge after rst_n deasserts.

Verification
REQ-034 Defaults, s_data=0x55 accepted -> txd per tick 0,1,0,1,0,1,0,1,0,1; frame_done one cycle after the 10th tick.
REQ-035 DATA_W=7, PARITY=1, 0x41 -> parity bit 0; PARITY=2, same data -> parity bit 1; FRAME_LEN=10.
REQ-036 STOP_BITS=2, LSB_FIRST=0, 0x80 -> txd 0,1,0,0,0,0,0,0,0,1,1; frame_done after the 11th tick.
REQ-037 s_valid held high with 0xA5 then 0x3C -> second start bit within 1 clk of frame_done; both frames bit-exact.
REQ-038 rst_n pulsed low after the 4th tick -> txd=1 and busy=0 at once, no frame_done; a new accept after release sends a correct frame.
REQ-039 baud_tick coincident with accept, plus ticks spaced 1 and 16 clks apart -> start bit lasts exactly one counted tick period; no bit is skipped or duplicated.
